// File: rtl/trig_pkg.sv
// Shared encodings for the trigger pulse sequencer: mode codes, FSM state
// codes and the minimum period the clamp logic enforces.
package trig_pkg;

  localparam logic [1:0] MODE_CONT  = 2'b00;
  localparam logic [1:0] MODE_BURST = 2'b01;
  localparam logic [1:0] MODE_EXT   = 2'b10;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_WAIT_EXT = 2'd2;

  // A period of 2 is the shortest that still leaves one low cycle per pulse.
  localparam int PERIOD_MIN = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous input into the clock domain through a flop chain
// and emits a one-cycle pulse on each synchronised rising edge.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/trigger_pulse_sequencer.sv
// Programmable periodic trigger generator: continuous, counted-burst and
// externally retriggered single-period modes with busy/done status.
module trigger_pulse_sequencer
  import trig_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int BURST_W     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_enable,
  input  logic [1:0]         i_mode,
  input  logic               i_start,
  input  logic               i_ext_trig,
  input  logic [CNT_W-1:0]   i_period,
  input  logic [CNT_W-1:0]   i_width,
  input  logic [BURST_W-1:0] i_burst_len,
  output logic               o_trigger_out,
  output logic               o_busy,
  output logic               o_done,
  output logic [BURST_W-1:0] o_pulse_cnt
);

  logic [1:0]         r_state;
  logic [1:0]         r_mode;
  logic [CNT_W-1:0]   r_period;
  logic [CNT_W-1:0]   r_width;
  logic [BURST_W-1:0] r_burstLen;
  logic [CNT_W-1:0]   r_phase;
  logic [BURST_W-1:0] r_pulseCnt;
  logic               r_trig;
  logic               r_busy;
  logic               r_done;

  logic               w_extRise;
  logic [1:0]         w_modeEff;
  logic [CNT_W-1:0]   w_periodClamp;
  logic [CNT_W-1:0]   w_widthClamp;
  logic [BURST_W-1:0] w_burstClamp;
  logic [BURST_W-1:0] w_pulseCntNext;
  logic               w_lastPhase;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_extSync (
    .clock   (clock),
    .reset   (reset),
    .i_async (i_ext_trig),
    .o_rise  (w_extRise)
  );

  // Clamp the live config so every latched value yields a legal waveform.
  assign w_modeEff      = (i_mode == 2'b11) ? MODE_CONT : i_mode;
  assign w_periodClamp  = (i_period < CNT_W'(PERIOD_MIN)) ? CNT_W'(PERIOD_MIN) : i_period;
  assign w_widthClamp   = (i_width >= w_periodClamp) ? (w_periodClamp - CNT_W'(1)) : i_width;
  assign w_burstClamp   = (i_burst_len == '0) ? BURST_W'(1) : i_burst_len;
  assign w_pulseCntNext = r_pulseCnt + BURST_W'(1);
  assign w_lastPhase    = (r_phase == (r_period - CNT_W'(1)));

  // Single FSM; the trigger register is loaded with the level of the next phase.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_CONT;
      r_period   <= '0;
      r_width    <= '0;
      r_burstLen <= '0;
      r_phase    <= '0;
      r_pulseCnt <= '0;
      r_trig     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!i_enable) begin
        r_state <= ST_IDLE;
        r_phase <= '0;
        r_trig  <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_modeEff == MODE_EXT) begin
              r_state    <= ST_WAIT_EXT;
              r_mode     <= MODE_EXT;
              r_pulseCnt <= '0;
            end else if (i_start) begin
              r_state    <= ST_RUN;
              r_mode     <= w_modeEff;
              r_period   <= w_periodClamp;
              r_width    <= w_widthClamp;
              r_burstLen <= w_burstClamp;
              r_phase    <= '0;
              r_pulseCnt <= '0;
              r_busy     <= 1'b1;
              r_trig     <= (w_widthClamp != '0);
            end
          end
          ST_WAIT_EXT: begin
            if (w_extRise) begin
              r_state    <= ST_RUN;
              r_period   <= w_periodClamp;
              r_width    <= w_widthClamp;
              r_burstLen <= w_burstClamp;
              r_phase    <= '0;
              r_busy     <= 1'b1;
              r_trig     <= (w_widthClamp != '0);
            end
          end
          ST_RUN: begin
            if (w_lastPhase) begin
              r_phase    <= '0;
              r_pulseCnt <= w_pulseCntNext;
              if (r_mode == MODE_EXT) begin
                r_state <= ST_WAIT_EXT;
                r_busy  <= 1'b0;
                r_trig  <= 1'b0;
                r_done  <= 1'b1;
              end else if ((r_mode == MODE_BURST) && (w_pulseCntNext == r_burstLen)) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_trig  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_trig <= (r_width != '0);
              end
            end else begin
              r_phase <= r_phase + CNT_W'(1);
              r_trig  <= ((r_phase + CNT_W'(1)) < r_width);
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_trig  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_trigger_out = r_trig;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_pulse_cnt   = r_pulseCnt;

endmodule

// File: doc/trigger_pulse_sequencer.md
Name: trigger_pulse_sequencer

Overview:
Programmable periodic trigger generator for the backscatter tag datapath. It drives the modulator and capture logic with configurable period, high width and burst count. Three modes: free-running, counted burst, and externally retriggered single pulse. Runtime config ports replace fixed-period trigger generation and report busy/done status to the controller.

Parameters:
CNT_W, 16, width of period/width counters; max period 2^CNT_W-1 clocks
BURST_W, 8, width of burst length and pulse counter
SYNC_STAGES, 2, synchroniser flops on ext_trig (>=2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  block enable; low aborts any activity
mode  in  2  00 continuous, 01 burst, 10 ext-retrigger, 11 reserved (treated as 00)
start  in  1  single-cycle start request (modes 00/01)
ext_trig  in  1  asynchronous external trigger (mode 10)
period  in  CNT_W  clocks per trigger period
width  in  CNT_W  clocks trigger_out is high per period
burst_len  in  BURST_W  pulses per burst (mode 01)
trigger_out  out  1  registered trigger pulse
busy  out  1  high while in RUN
done  out  1  one-cycle pulse at burst completion
pulse_cnt  out  BURST_W  pulses issued since last start, wraps

Behaviour:
- Reset: trigger_out=0, busy=0, done=0, pulse_cnt=0, state IDLE, counters 0, sync flops 0.
- States: IDLE, RUN, WAIT_EXT (mode 10 only).
- Config (mode, period, width, burst_len) is latched on the accepting edge and held until return to IDLE/WAIT_EXT; port changes mid-run have no effect.
- Clamping of latched values: period<2 -> 2; width>=period -> period-1 (guarantees >=1 low cycle); burst_len=0 -> 1. width=0 is legal: busy and counting proceed, trigger_out stays 0.
- IDLE: start=1 and enable=1 in modes 00/01 -> RUN, phase counter=0, pulse_cnt=0. In mode 10, enable=1 -> WAIT_EXT.
- Start latency: first trigger_out high cycle is the cycle right after the accepting edge. busy rises on the same edge.
- RUN: phase counts 0..period-1. trigger_out is high for phase 0..width-1. Phase wrap to 0 increments pulse_cnt.
- Mode 00: runs until enable=0. pulse_cnt wraps modulo 2^BURST_W.
- Mode 01: when phase=period-1 and pulse_cnt+1=burst_len -> IDLE. done=1 for exactly one cycle, busy=0 on the same edge.
- Mode 10: ext_trig passes through SYNC_STAGES flops plus a rising-edge detector. A detected edge in WAIT_EXT -> RUN for exactly one period, then back to WAIT_EXT with done pulsed. Latency from ext_trig rise to first trigger_out high is SYNC_STAGES+1 clocks. Edges detected during RUN are dropped, not queued.
- start while busy is ignored. start in mode 10 is ignored.
- enable=0 in any state: next edge -> IDLE, trigger_out=0, busy=0. done is not asserted. pulse_cnt holds its value.
- start and enable deasserting on the same edge: enable wins, no start.
- Reset mid-pulse: outputs drop asynchronously to reset values.

Decomposition:
- Shared package trig_pkg: mode encodings (MODE_CONT, MODE_BURST, MODE_EXT), state encoding, and the clamp minimum PERIOD_MIN=2.
- One sub-module, sync_edge_detect (SYNC_STAGES parameter): synchroniser plus rising-edge pulse for ext_trig.
- Clamp logic and FSM stay in the top module.

Test Plan:
- Mode 01, period=10, width=3, burst_len=4, start pulse -> 4 pulses of 3 high/7 low. busy high 40 cycles. done single cycle at end. pulse_cnt=4.
- Mode 00, period=5, width=2; drop enable after 23 cycles -> trigger_out low next cycle, busy=0, no done, pulse_cnt=4.
- Clamping, mode 01: period=1, width=7, burst_len=0 -> period 2, width 1, one pulse (1 high, 1 low), then done.
- Mode 10, period=8, width=2, SYNC_STAGES=2: ext_trig rise -> trigger_out high 3 clocks later for 2 clocks. A second ext_trig edge 4 cycles after the first produces no pulse. An edge after done yields a new pulse.
- Change period/width mid-burst (10->20) -> no effect until next start. start during busy -> ignored, pulse_cnt continues.
- Assert reset while trigger_out=1 mid-burst -> all outputs 0 immediately. After release, block idles until start.
